// File: rtl/restador_pkg.sv
// rtl/restador_pkg.sv - shared state encodings and counter-width helper for the serial subtractor
package restador_pkg;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        RESTA  = 2'd1,
        FIN    = 2'd2
    } estado_t;

    // Bits needed to count 0..n-1, never less than one
    function automatic int cnt_ancho(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/restador_if.sv
// rtl/restador_if.sv - operand/result handshake bundle for restador_serie
interface restador_if #(parameter int N = 8);
    logic         inicio;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] dif;
    logic         bout;
    logic         ocupado;
    logic         listo;

    modport master (output inicio, a, b, input dif, bout, ocupado, listo);
    modport slave  (input inicio, a, b, output dif, bout, ocupado, listo);
endinterface

// File: rtl/restador_completo.sv
// rtl/restador_completo.sv - combinational 1-bit full subtractor (x - y - bin)
module restador_completo (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/restador_serie.sv
// rtl/restador_serie.sv - bit-serial N-bit subtractor, LSB first; RESTADOR_SATURA_EN clamps borrowed results to 0
module restador_serie
    import restador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    restador_if.slave  bus
);
    localparam int CW = cnt_ancho(N);

    estado_t       estado;
    estado_t       estado_sig;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  res;
    logic [N-1:0]  res_sig;
    logic [CW-1:0] cnt;
    logic          brw;
    logic          d;
    logic          brw_sig;
    logic          ultimo;

    restador_completo u_bit (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (brw),
        .d    (d),
        .bout (brw_sig)
    );

    assign ultimo  = (cnt == CW'(N - 1));
    assign res_sig = {d, res[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= REPOSO;
        else        estado <= estado_sig;
    end

    always_comb begin
        estado_sig = REPOSO;
        case (estado)
            REPOSO: estado_sig = bus.inicio ? RESTA : REPOSO;
            RESTA:  estado_sig = ultimo ? FIN : RESTA;
            FIN:    estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    always_comb begin
        bus.ocupado = (estado == RESTA) || (estado == FIN);
        bus.listo   = (estado == FIN);
    end

    // dif/bout are committed on the last RESTA edge so they are already valid while listo is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            cnt      <= '0;
            brw      <= 1'b0;
            bus.dif  <= '0;
            bus.bout <= 1'b0;
        end else begin
            if (estado == REPOSO && bus.inicio) begin
                sa  <= bus.a;
                sb  <= bus.b;
                cnt <= '0;
                brw <= 1'b0;
            end else if (estado == RESTA) begin
                sa  <= {1'b0, sa[N-1:1]};
                sb  <= {1'b0, sb[N-1:1]};
                res <= res_sig;
                brw <= brw_sig;
                cnt <= cnt + 1'b1;
                if (ultimo) begin
`ifdef RESTADOR_SATURA_EN
                    bus.dif <= brw_sig ? '0 : res_sig;
`else
                    bus.dif <= res_sig;
`endif
                    bus.bout <= brw_sig;
                end
            end
        end
    end

endmodule

// File: tb/tb_restador_serie.sv
// tb/tb_restador_serie.sv - directed self-checking bench for restador_serie (N=8 and N=3)
module tb_restador_serie;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    restador_if #(.N(8)) bus8 ();
    restador_if #(.N(3)) bus3 ();

    restador_serie #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    restador_serie #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse inicio for one edge, then wait for listo; lat counts edges from the capture edge inclusive
    task automatic run8(input int av, input int bv, output int lat, output int occ);
        bus8.a      = av[7:0];
        bus8.b      = bv[7:0];
        bus8.inicio = 1'b1;
        tick();
        bus8.inicio = 1'b0;
        lat = 1;
        occ = 0;
        while (bus8.listo !== 1'b1 && lat < 30) begin
            if (bus8.ocupado === 1'b1) occ++;
            tick();
            lat++;
        end
        if (bus8.ocupado === 1'b1) occ++;
    endtask

    task automatic run3(input int av, input int bv, output int lat);
        bus3.a      = av[2:0];
        bus3.b      = bv[2:0];
        bus3.inicio = 1'b1;
        tick();
        bus3.inicio = 1'b0;
        lat = 1;
        while (bus3.listo !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int occ;
        int exp_d;
        int pulsos;
        int t_prev;
        int spacing_bad;

        bus8.inicio = 1'b0; bus8.a = '0; bus8.b = '0;
        bus3.inicio = 1'b0; bus3.a = '0; bus3.b = '0;
        #2;
        chk("rst_dif", int'(bus8.dif), 0);
        chk("rst_bout", int'(bus8.bout), 0);
        chk("rst_ocupado", int'(bus8.ocupado), 0);
        chk("rst_listo", int'(bus8.listo), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: 100 - 37
        run8(100, 37, lat, occ);
        chk("t1_latency", lat, 9);
        chk("t1_ocupado_cycles", occ, 9);
        chk("t1_dif", int'(bus8.dif), 63);
        chk("t1_bout", int'(bus8.bout), 0);
        tick();
        chk("t1_listo_pulse", int'(bus8.listo), 0);
        chk("t1_ocupado_end", int'(bus8.ocupado), 0);
        chk("t1_dif_hold", int'(bus8.dif), 63);

        // 3: 200 - 1 with a stray inicio (a=b=0) mid-operation
        bus8.a = 8'd200; bus8.b = 8'd1; bus8.inicio = 1'b1;
        tick();
        bus8.inicio = 1'b0;
        repeat (3) tick();
        bus8.a = 8'd0; bus8.b = 8'd0; bus8.inicio = 1'b1;
        tick();
        bus8.inicio = 1'b0;
        lat = 5;
        while (bus8.listo !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        chk("t3_latency", lat, 9);
        chk("t3_dif", int'(bus8.dif), 199);
        chk("t3_bout", int'(bus8.bout), 0);
        repeat (3) tick();
        chk("t3_no_restart", int'(bus8.ocupado), 0);

        // 2: 5 - 9 borrows
`ifdef RESTADOR_SATURA_EN
        exp_d = 0;
`else
        exp_d = 252;
`endif
        run8(5, 9, lat, occ);
        chk("t2_latency", lat, 9);
        chk("t2_dif", int'(bus8.dif), exp_d);
        chk("t2_bout", int'(bus8.bout), 1);
        tick();

        // 4: reset in the middle of 50 - 20
        bus8.a = 8'd50; bus8.b = 8'd20; bus8.inicio = 1'b1;
        tick();
        bus8.inicio = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("t4_rst_dif", int'(bus8.dif), 0);
        chk("t4_rst_bout", int'(bus8.bout), 0);
        chk("t4_rst_ocupado", int'(bus8.ocupado), 0);
        chk("t4_rst_listo", int'(bus8.listo), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        occ = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.listo === 1'b1 || bus8.ocupado === 1'b1) occ++;
        end
        chk("t4_no_listo_after_rst", occ, 0);
        run8(50, 20, lat, occ);
        chk("t4_fresh_latency", lat, 9);
        chk("t4_fresh_dif", int'(bus8.dif), 30);
        chk("t4_fresh_bout", int'(bus8.bout), 0);
        tick();

        // 5: inicio held high, listo spacing N+2
        bus8.a = 8'd10; bus8.b = 8'd3; bus8.inicio = 1'b1;
        pulsos = 0;
        t_prev = -1;
        spacing_bad = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (bus8.listo === 1'b1) begin
                if (t_prev >= 0 && (t - t_prev) != 10) spacing_bad++;
                t_prev = t;
                pulsos++;
            end
        end
        bus8.inicio = 1'b0;
        chk("t5_pulses", pulsos, 4);
        chk("t5_spacing_errors", spacing_bad, 0);
        chk("t5_dif", int'(bus8.dif), 7);
        repeat (12) tick();
        chk("t5_idle", int'(bus8.ocupado), 0);

        // 6: N=3 exhaustive
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                run3(ai, bi, lat);
`ifdef RESTADOR_SATURA_EN
                exp_d = (ai < bi) ? 0 : (ai - bi);
`else
                exp_d = (ai - bi + 8) % 8;
`endif
                chk($sformatf("t6_dif_%0d_%0d", ai, bi), int'(bus3.dif), exp_d);
                chk($sformatf("t6_bout_%0d_%0d", ai, bi), int'(bus3.bout), (ai < bi) ? 1 : 0);
                if (ai == 0 && bi == 0) chk("t6_latency", lat, 4);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
